// File: rtl/modulo_varredura_pkg.sv
// +--------------------------------------------------------------------+
// | modulo_varredura_pkg : shared encodings for the line scan sequencer |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package modulo_varredura_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BLANK  = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  localparam int NUM_LINES = 8;
  localparam int SEL_W     = 3;
  localparam logic [SEL_W-1:0] LAST_LINE = SEL_W'(NUM_LINES - 1);

endpackage

`default_nettype wire

// File: rtl/modulo_contador_intervalo.sv
// +--------------------------------------------------------------------+
// | modulo_contador_intervalo : loadable down-counter with zero flag    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module modulo_contador_intervalo #(
  parameter int TIMER_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  output logic               zero_o
);

  logic [TIMER_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - TIMER_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/modulo_varredura_8.sv
// +--------------------------------------------------------------------+
// | modulo_varredura_8 : select/enable scan sequencer for a 1:8 demux   |
// | Optional line mask port enabled by macro SCAN_MASK_EN.  Rev 1.0     |
// +--------------------------------------------------------------------+
`default_nettype none

module modulo_varredura_8
  import modulo_varredura_pkg::*;
#(
  parameter int DWELL_CYCLES = 4,
  parameter int BLANK_CYCLES = 2,
  parameter int TIMER_W      = 16
) (
  input  logic             input_clk,
  input  logic             input_reset,
  input  logic             input_run,
  input  logic             input_single,
`ifdef SCAN_MASK_EN
  input  logic [NUM_LINES-1:0] input_mask,
`endif
  output logic [SEL_W-1:0] out_sel,
  output logic             out_e,
  output logic             out_busy,
  output logic             out_frame_done
);

  localparam logic [TIMER_W-1:0] BLANK_LD = TIMER_W'(BLANK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DWELL_LD = TIMER_W'(DWELL_CYCLES - 1);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               e_q, e_d;
  logic               busy_q, done_q, done_d;
  logic               single_q, single_d;
  logic               en_d;
  logic               tmr_load, tmr_zero;
  logic [TIMER_W-1:0] tmr_val;

  modulo_contador_intervalo #(
    .TIMER_W(TIMER_W)
  ) u_timer (
    .clk_i     (input_clk),
    .rst_i     (input_reset),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .zero_o    (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    single_d = single_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = BLANK_LD;
    case (state_q)
      IDLE: begin
        sel_d = '0;
        if (input_run) begin
          state_d  = BLANK;
          single_d = 1'b0;
          tmr_load = 1'b1;
        end else if (input_single) begin
          state_d  = BLANK;
          single_d = 1'b1;
          tmr_load = 1'b1;
        end
      end
      BLANK: begin
        if (input_run) single_d = 1'b0;
        if (tmr_zero) begin
          state_d  = ACTIVE;
          tmr_load = 1'b1;
          tmr_val  = DWELL_LD;
        end
      end
      ACTIVE: begin
        if (input_run) single_d = 1'b0;
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (sel_q != LAST_LINE) begin
            sel_d   = sel_q + SEL_W'(1);
            state_d = BLANK;
          end else begin
            // Frame end: continue only for a continuous frame with run still held
            done_d  = 1'b1;
            sel_d   = '0;
            state_d = (input_run && !single_q) ? BLANK : IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

`ifdef SCAN_MASK_EN
  logic en_q;

  // Line enable is latched as each line's blanking slot begins
  always_comb begin
    en_d = en_q;
    if (state_d == BLANK && state_q != BLANK) en_d = input_mask[sel_d];
  end

  always_ff @(posedge input_clk) begin
    if (input_reset) en_q <= 1'b1;
    else             en_q <= en_d;
  end
`else
  assign en_d = 1'b1;
`endif

  assign e_d = (state_d == ACTIVE) && en_d;

  always_ff @(posedge input_clk) begin
    if (input_reset) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      e_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      single_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      e_q      <= e_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= done_d;
      single_q <= single_d;
    end
  end

  assign out_sel        = sel_q;
  assign out_e          = e_q;
  assign out_busy       = busy_q;
  assign out_frame_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_modulo_varredura_8.sv
// +--------------------------------------------------------------------+
// | tb_modulo_varredura_8 : directed bench for the 8-line scan sequencer|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_modulo_varredura_8;

  logic       clk = 1'b0;
  logic       rst, run, single;
  logic [2:0] sel;
  logic       e, busy, done;
`ifdef SCAN_MASK_EN
  logic [7:0] mask;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  modulo_varredura_8 dut (
    .input_clk     (clk),
    .input_reset   (rst),
    .input_run     (run),
    .input_single  (single),
`ifdef SCAN_MASK_EN
    .input_mask    (mask),
`endif
    .out_sel       (sel),
    .out_e         (e),
    .out_busy      (busy),
    .out_frame_done(done)
  );

  typedef struct {
    logic       rst;
    logic       run;
    logic       single;
    logic [5:0] exp;   // {sel, e, busy, done}
  } vec_t;

  vec_t tbl [17];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input int k, input logic [5:0] exp);
    logic [5:0] got;
    got = {sel, e, busy, done};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s k=%0d got{sel,e,busy,done}=%b want=%b", name, k, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  // Expected outputs k cycles after the start edge; 48-cycle frames of 8 x (2 blank + 4 dwell)
  function automatic logic [5:0] model(input int k, input int frames, input logic [7:0] m);
    int         p, f, line, pos;
    logic [2:0] s;
    p    = (k - 1) % 48;
    f    = (k - 1) / 48;
    line = p / 6;
    pos  = p % 6;
    s    = line[2:0];
    if (f >= frames) return {3'd0, 1'b0, 1'b0, ((k - 1) == frames * 48)};
    return {s, (pos >= 2) && m[line], 1'b1, (p == 0) && (f > 0)};
  endfunction

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; single = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int   viol, nd;
    int   dk [3];
    logic [2:0] psel;
    logic pe;

    rst = 1'b1; run = 1'b0; single = 1'b0;
`ifdef SCAN_MASK_EN
    mask = 8'hFF;
`endif

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 6'b000_0_0_0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 6'b000_0_0_0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 6'b000_0_0_0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 6'b000_0_0_0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 6'b000_0_1_0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 6'b000_0_1_0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 6'b000_1_1_0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 6'b000_1_1_0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 6'b000_1_1_0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 6'b000_1_1_0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 6'b001_0_1_0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 6'b001_0_1_0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 6'b001_1_1_0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 6'b001_1_1_0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 6'b001_1_1_0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 6'b001_1_1_0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 6'b010_0_1_0};

    // Reset, single-sweep start and a busy-time single pulse that must be ignored
    for (int i = 0; i < 17; i++) begin
      rst    = tbl[i].rst;
      run    = tbl[i].run;
      single = tbl[i].single;
      tick();
      check("table", i, tbl[i].exp);
    end

    // Remainder of the single sweep through frame_done and back to idle
    single = 1'b0;
    for (int k = 14; k <= 52; k++) begin
      tick();
      check("single", k, model(k, 1, 8'hFF));
    end

    // Continuous scanning: three frames back to back
    do_reset();
    run = 1'b1;
    viol = 0; nd = 0; psel = 3'd0; pe = 1'b0;
    dk[0] = 0; dk[1] = 0; dk[2] = 0;
    for (int k = 1; k <= 150; k++) begin
      tick();
      check("cont", k, model(k, 1000, 8'hFF));
      if (sel != psel && !(pe && !e)) viol++;
      if (done && nd < 3) begin
        dk[nd] = k;
        nd++;
      end
      psel = sel;
      pe   = e;
    end
    check_int("sel_glitch", viol, 0);
    check_int("done_count", nd, 3);
    check_int("period_a", dk[1] - dk[0], 48);
    check_int("period_b", dk[2] - dk[1], 48);

    // Run dropped during line 3: frame still completes, then idle
    do_reset();
    run = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      check("stop", k, model(k, 1, 8'hFF));
      if (k == 20) run = 1'b0;
    end

    // Reset during line 5 dwell, run held throughout
    do_reset();
    run = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      tick();
      check("pre_rst", k, model(k, 1000, 8'hFF));
    end
    rst = 1'b1;
    tick();
    check("rst_mid", 0, 6'b000_0_0_0);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("post_rst", k, model(k, 1000, 8'hFF));
    end

    // Single frame promoted to continuous by raising run mid-frame
    do_reset();
    single = 1'b1;
    tick();
    single = 1'b0;
    check("promote", 1, model(1, 1000, 8'hFF));
    for (int k = 2; k <= 60; k++) begin
      tick();
      check("promote", k, model(k, 1000, 8'hFF));
      if (k == 10) run = 1'b1;
    end
    run = 1'b0;

`ifdef SCAN_MASK_EN
    do_reset();
    mask = 8'b1010_0101;
    run  = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      check("mask", k, model(k, 1000, 8'b1010_0101));
    end
    run = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
